xgmii_crc32: RTL and testbench



---
 rtl/xgmii_pkg.sv | 37 +++
 rtl/crc32_d64_update.sv | 35 +++
 rtl/xgmii_crc32.sv | 86 ++++++++
 tb/tb_xgmii_crc32.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xgmii_pkg
// Brief    : Shared XGMII control codes, CRC-32 constants and frame states.
// Revision : 1.0 - initial release
// ============================================================================
package xgmii_pkg;

    localparam logic [7:0]  c_START             = 8'hFB;
    localparam logic [7:0]  c_TERM              = 8'hFD;
    localparam logic [7:0]  c_ERR               = 8'hFE;
    localparam logic [7:0]  c_IDLE              = 8'h07;

    localparam logic [31:0] c_CRC_POLY          = 32'hEDB88320;
    localparam logic [31:0] c_CRC_INIT_DEFAULT  = 32'hFFFFFFFF;
    localparam logic [31:0] c_CRC_XOROUT_DEFAULT = 32'hFFFFFFFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // Index of the lowest set bit; 8 when the mask is empty.
    function automatic logic [3:0] lowest_set_lane(input logic [7:0] mask);
        logic [3:0] idx;
        idx = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage : xgmii_pkg
`default_nettype wire

// File: rtl/crc32_d64_update.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : crc32_d64_update
// Brief    : Combinational reflected CRC-32 update over the first byte_cnt
//            lanes of a 64-bit word (lane 0 first).
// Revision : 1.0 - initial release
// ============================================================================
module crc32_d64_update
    import xgmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [3:0]  byte_cnt,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc_acc;

    always_comb begin
        w_crc_acc = crc_in;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < byte_cnt) begin
                w_crc_acc = w_crc_acc ^ {24'h000000, data[8*b +: 8]};
                for (int k = 0; k < 8; k++) begin
                    w_crc_acc = w_crc_acc[0] ? ((w_crc_acc >> 1) ^ c_CRC_POLY)
                                             : (w_crc_acc >> 1);
                end
            end
        end
        crc_out = w_crc_acc;
    end

endmodule : crc32_d64_update
`default_nettype wire

// File: rtl/xgmii_crc32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xgmii_crc32
// Brief    : Passive CRC-32 checker on a 64-bit XGMII receive stream.
// Revision : 1.0 - initial release
// ============================================================================
module xgmii_crc32
    import xgmii_pkg::*;
#(
    parameter logic [31:0] CRC_INIT   = c_CRC_INIT_DEFAULT,
    parameter logic [31:0] CRC_XOROUT = c_CRC_XOROUT_DEFAULT
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] xgmii_data,
    input  logic [7:0]  xgmii_ctrl,
    output logic [31:0] crc32_o,
    output logic        crc32_vld_o
);

    state_t      r_state;
    logic [31:0] r_crc;

    logic [3:0]  w_lane_idx;
    logic [7:0]  w_lane_byte;
    logic        w_has_ctrl;
    logic        w_is_term;
    logic        w_is_start;
    logic [3:0]  w_byte_cnt;
    logic [31:0] w_crc_next;

    // Only the lowest control lane decides the word's fate; later lanes are ignored.
    assign w_lane_idx  = lowest_set_lane(xgmii_ctrl);
    assign w_lane_byte = xgmii_data[{w_lane_idx[2:0], 3'b000} +: 8];
    assign w_has_ctrl  = |xgmii_ctrl;
    assign w_is_term   = w_has_ctrl && (w_lane_byte == c_TERM);
    assign w_is_start  = xgmii_ctrl[0] && (xgmii_data[7:0] == c_START);
    assign w_byte_cnt  = w_has_ctrl ? w_lane_idx : 4'd8;

    crc32_d64_update u_crc_update (
        .crc_in   (r_crc),
        .data     (xgmii_data),
        .byte_cnt (w_byte_cnt),
        .crc_out  (w_crc_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_crc       <= CRC_INIT;
            crc32_o     <= 32'h00000000;
            crc32_vld_o <= 1'b0;
        end else begin
            crc32_vld_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_start) begin
                        r_crc   <= CRC_INIT;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!w_has_ctrl) begin
                        r_crc <= w_crc_next;
                    end else if (w_is_term) begin
                        crc32_o     <= w_crc_next ^ CRC_XOROUT;
                        crc32_vld_o <= 1'b1;
                        r_crc       <= CRC_INIT;
                        r_state     <= ST_IDLE;
                    end else if (w_is_start) begin
                        // Start in lane 0 aborts the old frame and opens a new one.
                        r_crc <= CRC_INIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : xgmii_crc32
`default_nettype wire

// File: tb/tb_xgmii_crc32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xgmii_crc32
// Brief    : Self-checking bench: directed vector table plus randomized
//            traffic checked against a byte-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xgmii_crc32;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] xd;
    logic [7:0]  xc;
    logic [31:0] crc;
    logic        vld;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] W_START = 64'hD5555555555555FB;
    localparam logic [63:0] W_1_8   = 64'h3837363534333231;
    localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
    localparam logic [63:0] W_TERM0 = 64'h07070707070707FD;
    localparam logic [63:0] W_T9    = 64'h070707070707FD39;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic        v;
        logic [31:0] crc;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    bit          m_in_frame = 1'b0;
    byte unsigned m_q[$];
    logic [31:0] m_crc_out = 32'h0;
    logic [31:0] crc_tbl[256];

    always #5 clk = ~clk;

    xgmii_crc32 dut (
        .clk         (clk),
        .rstn        (rstn),
        .xgmii_data  (xd),
        .xgmii_ctrl  (xc),
        .crc32_o     (crc),
        .crc32_vld_o (vld)
    );

    function automatic void build_tbl();
        for (int n = 0; n < 256; n++) begin
            logic [31:0] v;
            v = 32'(n);
            for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
            crc_tbl[n] = v;
        end
    endfunction

    // Standard IEEE CRC-32 of a byte sequence, table-driven.
    function automatic logic [31:0] ref_crc(input byte unsigned q[$]);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (q[i]) r = crc_tbl[(r ^ 32'(q[i])) & 32'hFF] ^ (r >> 8);
        return r ^ 32'hFFFFFFFF;
    endfunction

    task automatic model_step(input logic [63:0] d, input logic [7:0] c, output logic ev);
        int k;
        ev = 1'b0;
        k  = 8;
        for (int i = 7; i >= 0; i--) if (c[i]) k = i;
        if (!m_in_frame) begin
            if (c[0] && d[7:0] == 8'hFB) begin
                m_in_frame = 1'b1;
                m_q.delete();
            end
        end else if (k == 8) begin
            for (int i = 0; i < 8; i++) m_q.push_back(d[8*i +: 8]);
        end else if (d[8*k +: 8] == 8'hFD) begin
            for (int i = 0; i < k; i++) m_q.push_back(d[8*i +: 8]);
            m_crc_out  = ref_crc(m_q);
            ev         = 1'b1;
            m_in_frame = 1'b0;
        end else if (k == 0 && d[7:0] == 8'hFB) begin
            m_q.delete();
        end else begin
            m_in_frame = 1'b0;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        xd = d;
        xc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_model(input logic [63:0] d, input logic [7:0] c, input string nm);
        logic ev;
        drive(d, c);
        model_step(d, c, ev);
        check({nm, " vld"}, {31'h0, vld}, {31'h0, ev});
        check({nm, " crc"}, crc, m_crc_out);
    endtask

    task automatic rand_word(output logic [63:0] d, output logic [7:0] c);
        int unsigned sel;
        int unsigned k;
        logic [7:0]  hi;
        logic [7:0]  codes[4];
        codes = '{8'hFE, 8'h07, 8'hFB, 8'h9C};
        sel = $urandom_range(0, 11);
        d   = {$urandom, $urandom};
        c   = 8'h00;
        if (sel <= 1) begin
            d = W_IDLE; c = 8'hFF;
        end else if (sel == 2) begin
            d = W_START; c = 8'h01;
        end else if (sel >= 9) begin
            k  = $urandom_range(0, 7);
            hi = 8'($urandom) & ~8'((2 << k) - 1);
            c  = hi | 8'(1 << k);
            d[8*k +: 8] = (sel == 11) ? codes[$urandom_range(0, 3)] : 8'hFD;
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  c;
        logic        ev;

        build_tbl();
        rstn = 1'b0;
        xd   = W_IDLE;
        xc   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset crc", crc, 32'h0);
        check("reset vld", {31'h0, vld}, 32'h0);
        rstn = 1'b1;

        vecs.push_back('{W_START, 8'h01, 1'b0, 32'h00000000});
        vecs.push_back('{W_1_8,   8'h00, 1'b0, 32'h00000000});
        vecs.push_back('{W_T9,    8'hFE, 1'b1, 32'hCBF43926});
        vecs.push_back('{W_START, 8'h01, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_1_8,   8'h00, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_TERM0, 8'hFF, 1'b1, 32'h9AE0DAAF});
        vecs.push_back('{W_START, 8'h01, 1'b0, 32'h9AE0DAAF});
        vecs.push_back('{W_TERM0, 8'hFF, 1'b1, 32'h00000000});
        vecs.push_back('{W_START, 8'h01, 1'b0, 32'h00000000});
        vecs.push_back('{W_1_8,   8'h00, 1'b0, 32'h00000000});
        vecs.push_back('{W_T9,    8'hFE, 1'b1, 32'hCBF43926});
        vecs.push_back('{W_START, 8'h01, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_1_8,   8'h00, 1'b0, 32'hCBF43926});
        vecs.push_back('{64'h07070707FE333231, 8'hF8, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_IDLE,  8'hFF, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_TERM0, 8'hFF, 1'b0, 32'hCBF43926});
        vecs.push_back('{64'hD5D5D5FB07070707, 8'h10, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_1_8,   8'h00, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_TERM0, 8'hFF, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_START, 8'h01, 1'b0, 32'hCBF43926});
        vecs.push_back('{64'hDEADBEEFCAFEF00D, 8'h00, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_START, 8'h01, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_1_8,   8'h00, 1'b0, 32'hCBF43926});
        vecs.push_back('{W_TERM0, 8'hFF, 1'b1, 32'h9AE0DAAF});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].d, vecs[i].c);
            model_step(vecs[i].d, vecs[i].c, ev);
            check($sformatf("vec%0d vld", i), {31'h0, vld}, {31'h0, vecs[i].v});
            check($sformatf("vec%0d crc", i), crc, vecs[i].crc);
        end

        for (int n = 0; n < 4000; n++) begin
            rand_word(d, c);
            drive_model(d, c, $sformatf("rand%0d", n));
        end

        drive_model(W_IDLE, 8'hFF, "idle_flush");
        for (int n = 0; n < 100; n++) begin
            drive(W_IDLE, 8'hFF);
            check($sformatf("idle%0d vld", n), {31'h0, vld}, 32'h0);
        end

        // Reset in the middle of a frame: outputs clear at once, frame abandoned.
        drive(W_START, 8'h01);
        drive(W_1_8, 8'h00);
        drive(W_T9, 8'hFE);
        check("pre_reset crc", crc, 32'hCBF43926);
        drive(W_START, 8'h01);
        drive(W_1_8, 8'h00);
        rstn = 1'b0;
        #1;
        check("async_reset crc", crc, 32'h0);
        check("async_reset vld", {31'h0, vld}, 32'h0);
        drive(W_T9, 8'hFE);
        check("held_reset vld", {31'h0, vld}, 32'h0);
        rstn = 1'b1;
        drive(W_T9, 8'hFE);
        check("post_reset term vld", {31'h0, vld}, 32'h0);
        check("post_reset term crc", crc, 32'h0);
        drive(W_START, 8'h01);
        drive(W_1_8, 8'h00);
        drive(W_T9, 8'hFE);
        check("post_reset frame vld", {31'h0, vld}, 32'h1);
        check("post_reset frame crc", crc, 32'hCBF43926);
        drive(W_IDLE, 8'hFF);
        check("single pulse", {31'h0, vld}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_xgmii_crc32
`default_nettype wire
